// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Optional feature macro used by the arbiter: BUS_ARB_TIMEOUT_EN.
package bus_arb_pkg;

  // Arbiter FSM: waiting for a request, or owning the slave port.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Master identifiers; M0 is the CPU load/store port, M1 the DMA/debug loader.
  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  // Read data returned to a master whose transaction was aborted by timeout.
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  // The master that did not win last time; used to break a tie.
  function automatic master_id_e other_master(input master_id_e id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; on a tie the master that was not granted
// last time wins, so neither master can starve the other.
module bus_arb_rr_pick
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_e last_gnt,
  output logic       gnt_valid,
  output master_id_e gnt_id
);

  // Pick the winner from the request vector and the previous grant.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = M0;
    unique case (req)
      2'b01:   gnt_id = M0;
      2'b10:   gnt_id = M1;
      2'b11:   gnt_id = other_master(last_gnt);
      default: gnt_id = M0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master, single-outstanding bus arbiter in front of the address decoder.
// M0 = CPU load/store port, M1 = DMA/debug loader. Round-robin grant,
// registered slave-side request and fields, one-cycle done pulses.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (abort a BUSY transaction after
// TIMEOUT_CYCLES cycles without s_ready; bus_err is tied low when undefined).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | slave port free; grant on the first cycle with a request that
//       | is not also a done cycle
// BUSY  | slave port owned by 'owner'; s_* fields frozen until s_ready
//       | (or timeout abort)
module bus_arbiter_2m
  import bus_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [2:0]    m0_strb,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_done,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [2:0]    m1_strb,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_done,

  output logic          s_req,
  output logic          s_we,
  output logic [2:0]    s_strb,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready,

  output logic          bus_err
);

  // A zero timeout would abort before the slave could ever answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bus_arbiter_2m: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e    state;
  master_id_e    last_gnt;
  master_id_e    owner;
  logic          pick_valid;
  master_id_e    pick_id;
  logic          done_cycle;
  logic          grant;
  logic          finish;
  logic          tmo_hit;
  logic [DW-1:0] cap_data;

  bus_arb_rr_pick u_pick (
    .req       ({m1_req, m0_req}),
    .last_gnt  (last_gnt),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  // A master still holds req during its done cycle; ignoring requests in that
  // cycle keeps the finished request from being granted a second time.
  assign done_cycle = m0_done | m1_done;
  assign grant      = (state == IDLE) && pick_valid && !done_cycle;
  assign finish     = (state == BUSY) && (s_ready || tmo_hit);

  // Slave data wins when it arrives; otherwise this is a timeout abort.
  assign cap_data   = s_ready ? s_rdata : DW'(DEADBEEF);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] tmo_cnt;

  // Remaining BUSY cycles without s_ready before abort; zero is terminal.
  assign tmo_hit = (state == BUSY) && !s_ready && (tmo_cnt == '0);

  // Down-counter reloaded on every grant, stepped on each unanswered BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (grant) begin
      tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    end else if ((state == BUSY) && !s_ready && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  // Error pulse coincides with the aborted master's done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Arbitration FSM with latched slave fields and per-master completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= M1;
      owner    <= M0;
      s_req    <= 1'b0;
      s_we     <= 1'b0;
      s_strb   <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            state <= BUSY;
            owner <= pick_id;
            s_req <= 1'b1;
            if (pick_id == M1) begin
              s_we    <= m1_we;
              s_strb  <= m1_strb;
              s_addr  <= m1_addr;
              s_wdata <= m1_wdata;
            end else begin
              s_we    <= m0_we;
              s_strb  <= m0_strb;
              s_addr  <= m0_addr;
              s_wdata <= m0_wdata;
            end
          end
        end
        BUSY: begin
          if (finish) begin
            state    <= IDLE;
            s_req    <= 1'b0;
            last_gnt <= owner;
            if (owner == M1) begin
              m1_rdata <= cap_data;
              m1_done  <= 1'b1;
            end else begin
              m0_rdata <= cap_data;
              m0_done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
`timescale 1ns/1ps
module tb_bus_arbiter_2m;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_done;
  logic [2:0]  m0_strb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_done;
  logic [2:0]  m1_strb;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_we, s_ready, bus_err;
  logic [2:0]  s_strb;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  // Scoreboard entry: {bus_err, master id, rdata}
  logic [33:0] exp_q[$];
  logic [33:0] mon_obs, mon_want;

  always #5 clk = ~clk;

  bus_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_strb  (m0_strb),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_rdata (m0_rdata),
    .m0_done  (m0_done),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_strb  (m1_strb),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_rdata (m1_rdata),
    .m1_done  (m1_done),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_strb   (s_strb),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .bus_err  (bus_err)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_sreq(input string tag);
    int n = 0;
    while (!s_req && n < 20) begin
      step();
      n++;
    end
    check({tag, "_sreq"}, s_req, 1'b1);
  endtask

  // Slave side of one transaction: check frozen fields for lat+1 BUSY cycles,
  // then answer with rdata and expect the owner's done pulse next cycle.
  task automatic serve(input string tag, input logic id, input logic we,
                       input logic [2:0] strb, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int lat);
    wait_sreq(tag);
    for (int i = 0; i <= lat; i++) begin
      check({tag, "_fields"}, {s_we, s_strb, s_addr, s_wdata}, {we, strb, addr, wdata});
      if (i < lat) step();
    end
    exp_q.push_back({1'b0, id, rdata});
    s_ready = 1'b1;
    s_rdata = rdata;
    step();
    s_ready = 1'b0;
    s_rdata = '0;
    check({tag, "_done"}, id ? m1_done : m0_done, 1'b1);
  endtask

  // Done monitor: every completion must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && (m0_done || m1_done)) begin
      check("done_exclusive", m0_done & m1_done, 1'b0);
      mon_obs = {bus_err, m1_done, m1_done ? m1_rdata : m0_rdata};
      if (exp_q.size() == 0) begin
        check("unexpected_done", exp_q.size(), 1);
      end else begin
        mon_want = exp_q.pop_front();
        check("xact", mon_obs, mon_want);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int hi;
    int dn;
    int n;
    reset   = 1'b1;
    m0_req  = 0; m0_we = 0; m0_strb = '0; m0_addr = '0; m0_wdata = '0;
    m1_req  = 0; m1_we = 0; m1_strb = '0; m1_addr = '0; m1_wdata = '0;
    s_ready = 0; s_rdata = '0;
    do_reset();

    check("rst_sreq", s_req, 1'b0);
    check("rst_done", {m0_done, m1_done, bus_err}, 3'b000);
    check("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    check("rst_sfields", {s_we, s_strb, s_addr, s_wdata}, 68'd0);

    // 1: single M0 read
    m0_req = 1; m0_we = 0; m0_strb = 3'b010; m0_addr = 32'h1000; m0_wdata = '0;
    step();
    check("t1_sreq_lat", s_req, 1'b1);
    serve("t1", 1'b0, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h1234_5678, 2);
    m0_req = 0;
    check("t1_rdata", m0_rdata, 32'h1234_5678);
    step();
    check("t1_done_pulse", m0_done, 1'b0);

    // 2: simultaneous requests after reset alternate M0, M1, M0, M1
    do_reset();
    m0_addr = 32'h100; m0_strb = 3'b010;
    m1_addr = 32'h200; m1_strb = 3'b000; m1_we = 0; m1_wdata = '0;
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < 4; k++) begin
      serve($sformatf("t2_%0d", k), k[0], 1'b0, k[0] ? 3'b000 : 3'b010,
            k[0] ? 32'h200 : 32'h100, 32'h0, 32'hA000_0000 + k, 0);
      if (k == 1) check("t2_m0_hold", m0_rdata, 32'hA000_0000);
      if (k < 3) begin
        step();
        check("t2_gap", s_req, 1'b0);
      end
    end
    m0_req = 0; m1_req = 0;
    step();

    // 3: M1 write, fields frozen while M1 changes its outputs
    m1_req = 1; m1_we = 1; m1_strb = 3'b010; m1_addr = 32'h2000; m1_wdata = 32'hCAFE_F00D;
    step();
    m1_addr = 32'h3000; m1_wdata = 32'h0; m1_we = 0; m1_strb = 3'b111;
    serve("t3", 1'b1, 1'b1, 3'b010, 32'h2000, 32'hCAFE_F00D, 32'h0BAD_0001, 2);
    m1_req = 0;
    check("t3_rdata", m1_rdata, 32'h0BAD_0001);
    step();

    // 4: reset in BUSY drops the transaction
    m0_req = 1; m0_we = 0; m0_strb = 3'b010; m0_addr = 32'h4000;
    wait_sreq("t4");
    step();
    reset = 1;
    step();
    check("t4_sreq_drop", s_req, 1'b0);
    check("t4_no_done", {m0_done, m1_done}, 2'b00);
    m0_req = 0;
    reset = 0;
    step();
    check("t4_rdata_clr", m0_rdata, 32'h0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      dn += int'(m0_done | m1_done);
      step();
    end
    check("t4_quiet", dn, 0);
    m0_req = 1; m0_addr = 32'h4004;
    serve("t4b", 1'b0, 1'b0, 3'b010, 32'h4004, 32'h0, 32'h55AA_55AA, 1);
    m0_req = 0;
    step();

    // 5: M0 requests continuously, M1 once; M1 served right after one M0 transaction
    m0_req = 1; m0_addr = 32'h5000;
    step();
    m1_req = 1; m1_we = 0; m1_strb = 3'b000; m1_addr = 32'h6000; m1_wdata = '0;
    serve("t5a", 1'b0, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h0000_0050, 1);
    serve("t5b", 1'b1, 1'b0, 3'b000, 32'h6000, 32'h0, 32'h0000_0060, 0);
    m1_req = 0;
    serve("t5c", 1'b0, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h0000_0051, 0);
    m0_req = 0;
    step();

    // 6: slave never answers
    m0_req = 1; m0_addr = 32'h7000;
`ifdef BUS_ARB_TIMEOUT_EN
    exp_q.push_back({1'b1, 1'b0, 32'hDEAD_BEEF});
    wait_sreq("t6");
    n = 0;
    while (!m0_done && n < 20) begin
      step();
      n++;
    end
    check("t6_abort_cycles", n, 4);
    check("t6_err_done", {bus_err, m0_done}, 2'b11);
    check("t6_rdata", m0_rdata, 32'hDEAD_BEEF);
    m0_req = 0;
    step();
    check("t6_err_pulse", bus_err, 1'b0);
`else
    wait_sreq("t6");
    hi = 0;
    dn = 0;
    n  = 0;
    for (int i = 0; i < 100; i++) begin
      hi += int'(s_req);
      dn += int'(m0_done | m1_done);
      n  += int'(bus_err);
      step();
    end
    check("t6_sreq_hold", hi, 100);
    check("t6_no_done", dn, 0);
    check("t6_no_err", n, 0);
    m0_req = 0;
    do_reset();
`endif

    step();
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
